// File: rtl/sts_sync_ctrl.sv
// sts_sync_ctrl: sequencing controller for the 802.11a short-training-sequence
// coarse-CFO path. Arms the delay line, waits out its fill period, finds the
// autocorrelation plateau, gates the phase accumulator over a fixed window,
// hands off to the CFO estimator and enables the corrector until frame end.
//
// Optional build macro: STS_AUTO_REARM_EN
//   defined   - a SEARCH timeout re-enters FILL after a one-cycle delay-line
//               flush (delay_enable low for that cycle).
//   undefined - every timeout returns to IDLE.
module sts_sync_ctrl #(
  parameter int FILL_LEN       = 32,
  parameter int PLATEAU_LEN    = 48,
  parameter int EST_LEN        = 64,
  parameter int SEARCH_TIMEOUT = 8192,
  parameter int EST_TIMEOUT    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_in_valid,
  input  logic       metric_above,
  input  logic       est_done,
  input  logic       frame_done,
  output logic       delay_enable,
  output logic       acc_clear,
  output logic       acc_en,
  output logic       est_start,
  output logic       cfo_apply_en,
  output logic       sts_detected,
  output logic       err_timeout,
  output logic       busy,
  output logic [2:0] state
);

  // Smallest width (at least 1) able to hold 0 .. value-1.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_SEARCH   = 3'd2;
  localparam logic [2:0] S_ACCUM    = 3'd3;
  localparam logic [2:0] S_WAIT_EST = 3'd4;
  localparam logic [2:0] S_APPLY    = 3'd5;

  // The shared sample counter serves FILL, the SEARCH timeout and ACCUM.
  localparam int SMP_MAX_A = (FILL_LEN > EST_LEN) ? FILL_LEN : EST_LEN;
  localparam int SMP_MAX   = (SMP_MAX_A > SEARCH_TIMEOUT) ? SMP_MAX_A : SEARCH_TIMEOUT;
  localparam int SMP_W     = clogb2(SMP_MAX);
  localparam int RUN_W     = clogb2(PLATEAU_LEN);
  localparam int CYC_W     = clogb2(EST_TIMEOUT);

  localparam logic [SMP_W-1:0] FILL_LAST = SMP_W'(FILL_LEN - 1);
  localparam logic [SMP_W-1:0] SRCH_LAST = SMP_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SMP_W-1:0] ACC_LAST  = SMP_W'(EST_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(PLATEAU_LEN - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(EST_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [SMP_W-1:0] smp_q;
  logic [RUN_W-1:0] run_q;
  logic [CYC_W-1:0] cyc_q;
  logic             acc_clear_d, sts_d, est_start_d, err_d;
  logic             flush_q;
`ifdef STS_AUTO_REARM_EN
  logic             flush_d;
`endif

  // Next-state and one-shot pulse decode; abort overrides every transition.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    acc_clear_d = 1'b0;
    sts_d       = 1'b0;
    est_start_d = 1'b0;
    err_d       = 1'b0;
`ifdef STS_AUTO_REARM_EN
    flush_d     = 1'b0;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_FILL;
            acc_clear_d = 1'b1;
          end
        end
        S_FILL: begin
          if (sample_in_valid && !flush_q && smp_q == FILL_LAST) state_d = S_SEARCH;
        end
        S_SEARCH: begin
          if (sample_in_valid) begin
            // A plateau completing on the timeout sample still counts as found.
            if (metric_above && run_q == RUN_LAST) begin
              state_d     = S_ACCUM;
              acc_clear_d = 1'b1;
              sts_d       = 1'b1;
            end else if (smp_q == SRCH_LAST) begin
              err_d = 1'b1;
`ifdef STS_AUTO_REARM_EN
              state_d     = S_FILL;
              acc_clear_d = 1'b1;
              flush_d     = 1'b1;
`else
              state_d     = S_IDLE;
`endif
            end
          end
        end
        S_ACCUM: begin
          if (sample_in_valid && smp_q == ACC_LAST) begin
            state_d     = S_WAIT_EST;
            est_start_d = 1'b1;
          end
        end
        S_WAIT_EST: begin
          // A result arriving on the timeout cycle wins over the timeout.
          if (est_done) begin
            state_d = S_APPLY;
          end else if (cyc_q == CYC_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_APPLY: begin
          if (frame_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, pulse and counter registers; all counters restart on a state change.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      smp_q        <= '0;
      run_q        <= '0;
      cyc_q        <= '0;
      acc_clear    <= 1'b0;
      sts_detected <= 1'b0;
      est_start    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_clear    <= acc_clear_d;
      sts_detected <= sts_d;
      est_start    <= est_start_d;
      err_timeout  <= err_d;
      if (state_d != state_q) begin
        smp_q <= '0;
        run_q <= '0;
        cyc_q <= '0;
      end else begin
        if (sample_in_valid && !flush_q &&
            (state_q == S_FILL || state_q == S_SEARCH || state_q == S_ACCUM))
          smp_q <= smp_q + 1'b1;
        if (state_q == S_SEARCH && sample_in_valid)
          run_q <= metric_above ? run_q + 1'b1 : '0;
        if (state_q == S_WAIT_EST)
          cyc_q <= cyc_q + 1'b1;
      end
    end
  end

`ifdef STS_AUTO_REARM_EN
  // One-cycle delay-line flush marker on the FILL re-entry after a search timeout.
  always_ff @(posedge clk) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= flush_d;
  end
`else
  assign flush_q = 1'b0;
`endif

  assign state        = state_q;
  assign delay_enable = (state_q inside {S_FILL, S_SEARCH, S_ACCUM, S_WAIT_EST, S_APPLY}) && !flush_q;
  assign acc_en       = (state_q == S_ACCUM) && sample_in_valid;
  assign cfo_apply_en = (state_q == S_APPLY);
  assign busy         = (state_q != S_IDLE);

endmodule
